// File: rtl/led_seq_pkg.sv
// Shared types, pattern table and index helpers for the LED pattern sequencer.
// Pattern table and step count here must agree with the top-level NUM_STEPS parameter.
package led_seq_pkg;

    localparam int NUM_STEPS = 6;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } seq_state_t;

    localparam logic [3:0] PAT_0 = 4'b1111;
    localparam logic [3:0] PAT_1 = 4'b1010;
    localparam logic [3:0] PAT_2 = 4'b0101;
    localparam logic [3:0] PAT_3 = 4'b0000;
    localparam logic [3:0] PAT_4 = 4'b1110;
    localparam logic [3:0] PAT_5 = 4'b0111;

    localparam logic [3:0] RESET_PATTERN = PAT_0;

    // Indices outside the table fall back to the reset pattern.
    function automatic logic [3:0] pattern_of(input logic [IDX_W-1:0] idx);
        logic [3:0] pat;
        case (idx)
            3'd0:    pat = PAT_0;
            3'd1:    pat = PAT_1;
            3'd2:    pat = PAT_2;
            3'd3:    pat = PAT_3;
            3'd4:    pat = PAT_4;
            3'd5:    pat = PAT_5;
            default: pat = RESET_PATTERN;
        endcase
        return pat;
    endfunction

    // An out-of-range index always recovers to step 0 on its next advance.
    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                    input logic             dir,
                                                    input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] nxt;
        if (idx > last) begin
            nxt = '0;
        end else if (!dir) begin
            nxt = (idx == last) ? '0 : idx + IDX_W'(1);
        end else begin
            nxt = (idx == '0) ? last : idx - IDX_W'(1);
        end
        return nxt;
    endfunction

    function automatic logic is_wrap(input logic [IDX_W-1:0] idx,
                                     input logic             dir,
                                     input logic [IDX_W-1:0] last);
        return (!dir && (idx == last)) || (dir && (idx == '0));
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Command/status bundle between the sequencer and its controlling logic.
// Optional macro LED_SEQ_LOOP_LIMIT_EN adds loop_limit and done.
interface led_pattern_sequencer_if #(
    parameter int DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic               step_req;
    logic               dir;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         led;
    logic [2:0]         step_idx;
    logic               running;
    logic               wrap;
`ifdef LED_SEQ_LOOP_LIMIT_EN
    logic [7:0]         loop_limit;
    logic               done;

    modport master (
        output start, stop, step_req, dir, dwell, loop_limit,
        input  led, step_idx, running, wrap, done
    );

    modport slave (
        input  start, stop, step_req, dir, dwell, loop_limit,
        output led, step_idx, running, wrap, done
    );
`else
    modport master (
        output start, stop, step_req, dir, dwell,
        input  led, step_idx, running, wrap
    );

    modport slave (
        input  start, stop, step_req, dir, dwell,
        output led, step_idx, running, wrap
    );
`endif
endinterface

// File: rtl/led_seq_dwell_timer.sv
// Dwell timer: holds the per-step period and pulses tc on the last cycle of each period.
// A zero dwell request is stretched to one cycle so the sequencer never stalls.
module led_seq_dwell_timer #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_a,
    input  logic               load,
    input  logic               clear,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tc
);

    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] period;
    logic [DWELL_W-1:0] dwell_eff;
    logic               at_end;

    assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign at_end    = (count == period - DWELL_W'(1));
    assign tc        = enable && !clear && !load && at_end;

    // Period is re-latched at every terminal count so dwell changes apply per step.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            count  <= '0;
            period <= DWELL_W'(1);
        end else if (clear) begin
            count  <= '0;
        end else if (load) begin
            count  <= '0;
            period <= dwell_eff;
        end else if (enable) begin
            if (at_end) begin
                count  <= '0;
                period <= dwell_eff;
            end else begin
                count  <= count + DWELL_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Command-driven sequencer stepping a fixed 6-entry LED pattern table (run / stop / single step).
// Optional macro LED_SEQ_LOOP_LIMIT_EN stops free-running after a programmed number of wraps.
module led_pattern_sequencer #(
    parameter int DWELL_W   = 16,
    parameter int NUM_STEPS = led_seq_pkg::NUM_STEPS
) (
    input logic                    clk,
    input logic                    rst_a,
    led_pattern_sequencer_if.slave bus
);
    import led_seq_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STEPS - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [IDX_W-1:0] step_idx_q;
    logic [IDX_W-1:0] idx_next;
    logic [3:0]       led_q;
    logic             running_q;
    logic             wrap_q;
    logic             idx_wraps;
    logic             advance;
    logic             timer_load;
    logic             timer_clear;
    logic             timer_en;
    logic             tc;
    logic             loop_clr;
`ifdef LED_SEQ_LOOP_LIMIT_EN
    logic [7:0]       loop_cnt;
    logic             limit_hit;
    logic             done_q;
`endif

    assign idx_next  = next_index(step_idx_q, bus.dir, LAST_IDX);
    assign idx_wraps = is_wrap(step_idx_q, bus.dir, LAST_IDX);

    led_seq_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk    (clk),
        .rst_a  (rst_a),
        .load   (timer_load),
        .clear  (timer_clear),
        .enable (timer_en),
        .dwell  (bus.dwell),
        .tc     (tc)
    );

    // stop outranks start, which outranks step_req; a stop in RUN discards a coincident tc.
    always_comb begin
        state_next  = state;
        advance     = 1'b0;
        timer_load  = 1'b0;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        loop_clr    = bus.stop;
`ifdef LED_SEQ_LOOP_LIMIT_EN
        limit_hit   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.stop) begin
                    state_next = IDLE;
                end else if (bus.start) begin
                    state_next = RUN;
                    timer_load = 1'b1;
                    loop_clr   = 1'b1;
                end else if (bus.step_req) begin
                    state_next = STEP;
                end
            end
            STEP: begin
                advance    = 1'b1;
                state_next = IDLE;
            end
            RUN: begin
                if (bus.stop) begin
                    state_next  = IDLE;
                    timer_clear = 1'b1;
                end else begin
                    timer_en = 1'b1;
                    if (tc) begin
                        advance = 1'b1;
`ifdef LED_SEQ_LOOP_LIMIT_EN
                        if (idx_wraps && (bus.loop_limit != 8'd0) &&
                            (loop_cnt + 8'd1 == bus.loop_limit)) begin
                            limit_hit  = 1'b1;
                            state_next = IDLE;
                        end
`endif
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            state      <= IDLE;
            step_idx_q <= '0;
            led_q      <= RESET_PATTERN;
            running_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state     <= state_next;
            running_q <= (state_next == RUN);
            wrap_q    <= advance && idx_wraps;
            if (advance) begin
                step_idx_q <= idx_next;
                led_q      <= pattern_of(idx_next);
            end
        end
    end

`ifdef LED_SEQ_LOOP_LIMIT_EN
    // Only wraps taken while free-running count towards the limit.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            loop_cnt <= 8'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= limit_hit;
            if (loop_clr || limit_hit) begin
                loop_cnt <= 8'd0;
            end else if ((state == RUN) && advance && idx_wraps) begin
                loop_cnt <= loop_cnt + 8'd1;
            end
        end
    end

    assign bus.done = done_q;
`else
    logic unused_loop_clr;
    assign unused_loop_clr = loop_clr;
`endif

    assign bus.led      = led_q;
    assign bus.step_idx = step_idx_q;
    assign bus.running  = running_q;
    assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised self-checking bench for led_pattern_sequencer against a step-level behavioural model.
// Build with LED_SEQ_LOOP_LIMIT_EN defined to also exercise the loop-limit feature.
module tb_led_pattern_sequencer;

    localparam int DWELL_W = 16;
`ifdef LED_SEQ_LOOP_LIMIT_EN
    localparam int VW = 10;
`else
    localparam int VW = 9;
`endif

    logic clk;
    logic rst_a;
    int   total;
    int   bad;

    led_pattern_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    led_pattern_sequencer #(
        .DWELL_W   (DWELL_W),
        .NUM_STEPS (6)
    ) dut (
        .clk   (clk),
        .rst_a (rst_a),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a position on a 6-step ring plus a countdown to the next move.
    logic [3:0] pat_tab [6] = '{4'b1111, 4'b1010, 4'b0101, 4'b0000, 4'b1110, 4'b0111};
    int m_idx;
    bit m_run;
    bit m_step_pending;
    bit m_wrap;
    bit m_done;
    int m_left;
    int m_loops;

    function automatic void model_edge(bit r, bit st, bit sp, bit sr, bit d, int dw, int lim);
        bit adv;
        bit run_adv;
        int per;
        adv     = 0;
        run_adv = 0;
        m_wrap  = 0;
        m_done  = 0;
        per     = (dw == 0) ? 1 : dw;
        if (r) begin
            m_idx = 0; m_run = 0; m_step_pending = 0; m_left = 0; m_loops = 0;
            return;
        end
        if (sp) m_loops = 0;
        if (m_step_pending) begin
            adv = 1;
            m_step_pending = 0;
        end else if (!m_run) begin
            if (!sp && st) begin
                m_run = 1; m_left = per; m_loops = 0;
            end else if (!sp && sr) begin
                m_step_pending = 1;
            end
        end else if (sp) begin
            m_run = 0;
        end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                adv = 1; run_adv = 1; m_left = per;
            end
        end
        if (adv) begin
            if (d) begin
                m_wrap = (m_idx == 0);
                m_idx  = (m_idx + 5) % 6;
            end else begin
                m_wrap = (m_idx == 5);
                m_idx  = (m_idx + 1) % 6;
            end
            if (run_adv && m_wrap) begin
                m_loops = m_loops + 1;
                if (lim != 0 && m_loops == lim) begin
                    m_run = 0; m_done = 1; m_loops = 0;
                end
            end
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
`ifdef LED_SEQ_LOOP_LIMIT_EN
        return {pat_tab[m_idx], 3'(m_idx), m_run, m_wrap, m_done};
`else
        return {pat_tab[m_idx], 3'(m_idx), m_run, m_wrap};
`endif
    endfunction

    function automatic logic [VW-1:0] dut_vec();
`ifdef LED_SEQ_LOOP_LIMIT_EN
        return {bus.led, bus.step_idx, bus.running, bus.wrap, bus.done};
`else
        return {bus.led, bus.step_idx, bus.running, bus.wrap};
`endif
    endfunction

    task automatic tick();
        bit r, st, sp, sr, d;
        int dw, lim;
        r   = rst_a;
        st  = bus.start;
        sp  = bus.stop;
        sr  = bus.step_req;
        d   = bus.dir;
        dw  = int'(bus.dwell);
        lim = 0;
`ifdef LED_SEQ_LOOP_LIMIT_EN
        lim = int'(bus.loop_limit);
`endif
        @(posedge clk);
        model_edge(r, st, sp, sr, d, dw, lim);
        #1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] ev, dv;
        rst_a = 1'b1;
        tick();
        tick();
        ev = exp_vec(); dv = dut_vec(); total++;
        if (dv !== ev) begin bad++; $display("FAIL reset_hold got=%b expected=%b", dv, ev); end
        rst_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            ev = exp_vec(); dv = dut_vec(); total++;
            if (dv !== ev) begin bad++; $display("FAIL reset_idle cyc=%0d got=%b expected=%b", i, dv, ev); end
        end
    endtask

    task automatic test_run_forward();
        logic [VW-1:0] ev, dv;
        bus.dwell = 16'd3; bus.dir = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ev = exp_vec(); dv = dut_vec(); total++;
        if (dv !== ev) begin bad++; $display("FAIL run_fwd_start got=%b expected=%b", dv, ev); end
        for (int i = 0; i < 20; i++) begin
            tick();
            ev = exp_vec(); dv = dut_vec(); total++;
            if (dv !== ev) begin bad++; $display("FAIL run_fwd cyc=%0d got=%b expected=%b", i, dv, ev); end
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        ev = exp_vec(); dv = dut_vec(); total++;
        if (dv !== ev) begin bad++; $display("FAIL run_fwd_stop got=%b expected=%b", dv, ev); end
    endtask

    task automatic test_run_reverse_dwell0();
        logic [VW-1:0] ev, dv;
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        bus.dwell = 16'd0; bus.dir = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            ev = exp_vec(); dv = dut_vec(); total++;
            if (dv !== ev) begin bad++; $display("FAIL run_rev0 cyc=%0d got=%b expected=%b", i, dv, ev); end
        end
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    endtask

    task automatic test_step();
        logic [VW-1:0] ev, dv;
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        bus.dir = 1'b0;
        for (int p = 0; p < 3; p++) begin
            bus.step_req = 1'b1;
            tick();
            bus.step_req = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                ev = exp_vec(); dv = dut_vec(); total++;
                if (dv !== ev) begin bad++; $display("FAIL step p=%0d cyc=%0d got=%b expected=%b", p, i, dv, ev); end
            end
        end
        bus.stop = 1'b1; bus.start = 1'b1;
        tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            ev = exp_vec(); dv = dut_vec(); total++;
            if (dv !== ev) begin bad++; $display("FAIL stop_start cyc=%0d got=%b expected=%b", i, dv, ev); end
        end
        bus.step_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            ev = exp_vec(); dv = dut_vec(); total++;
            if (dv !== ev) begin bad++; $display("FAIL step_held cyc=%0d got=%b expected=%b", i, dv, ev); end
        end
        bus.step_req = 1'b0;
        tick();
    endtask

    task automatic test_stop_on_tc();
        logic [VW-1:0] ev, dv;
        bus.dwell = 16'd5; bus.dir = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ev = exp_vec(); dv = dut_vec(); total++;
            if (dv !== ev) begin bad++; $display("FAIL stop_tc cyc=%0d got=%b expected=%b", i, dv, ev); end
            tick();
        end
    endtask

    task automatic test_reset_midrun();
        logic [VW-1:0] ev, dv;
        bus.dwell = 16'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_a = 1'b1;
        tick();
        ev = exp_vec(); dv = dut_vec(); total++;
        if (dv !== ev) begin bad++; $display("FAIL reset_midrun got=%b expected=%b", dv, ev); end
        rst_a = 1'b0;
        tick();
        ev = exp_vec(); dv = dut_vec(); total++;
        if (dv !== ev) begin bad++; $display("FAIL reset_midrun_after got=%b expected=%b", dv, ev); end
    endtask

    task automatic test_dir_change();
        logic [VW-1:0] ev, dv;
        bus.dwell = 16'd4; bus.dir = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 6) bus.dir = 1'b1;
            if (i == 9) bus.dwell = 16'd2;
            tick();
            ev = exp_vec(); dv = dut_vec(); total++;
            if (dv !== ev) begin bad++; $display("FAIL dir_change cyc=%0d got=%b expected=%b", i, dv, ev); end
        end
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    endtask

    task automatic test_random();
        logic [VW-1:0] ev, dv;
        for (int i = 0; i < 500; i++) begin
            bus.start    = ($urandom_range(0, 9) == 0);
            bus.stop     = ($urandom_range(0, 15) == 0);
            bus.step_req = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) bus.dir = ~bus.dir;
            if ($urandom_range(0, 11) == 0) bus.dwell = 16'($urandom_range(0, 4));
            rst_a = ($urandom_range(0, 199) == 0);
            tick();
            ev = exp_vec(); dv = dut_vec(); total++;
            if (dv !== ev) begin bad++; $display("FAIL random cyc=%0d got=%b expected=%b", i, dv, ev); end
        end
        rst_a = 1'b0; bus.start = 1'b0; bus.stop = 1'b0; bus.step_req = 1'b0;
        tick();
    endtask

`ifdef LED_SEQ_LOOP_LIMIT_EN
    task automatic test_loop_limit();
        logic [VW-1:0] ev, dv;
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        bus.loop_limit = 8'd2; bus.dwell = 16'd1; bus.dir = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            ev = exp_vec(); dv = dut_vec(); total++;
            if (dv !== ev) begin bad++; $display("FAIL loop_limit cyc=%0d got=%b expected=%b", i, dv, ev); end
        end
        bus.loop_limit = 8'd0;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst_a = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.step_req = 1'b0;
        bus.dir = 1'b0; bus.dwell = 16'd1;
`ifdef LED_SEQ_LOOP_LIMIT_EN
        bus.loop_limit = 8'd0;
`endif
        m_idx = 0; m_run = 0; m_step_pending = 0; m_wrap = 0; m_done = 0; m_left = 0; m_loops = 0;
        test_reset();
        test_run_forward();
        test_run_reverse_dwell0();
        test_step();
        test_stop_on_tc();
        test_reset_midrun();
        test_dir_change();
`ifdef LED_SEQ_LOOP_LIMIT_EN
        test_loop_limit();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
